// File: rtl/mbscore_int_arbiter.sv
// mbscore_int_arbiter: edge-latched, masked, priority interrupt entry sequencer; define MBSCORE_INT_NEST_EN for preemptive nesting
module mbscore_int_arbiter #(
  parameter int INT_SEL_WIDTH = 7,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE = 32'h0000_0100,
  parameter int VEC_STRIDE = 16,
  parameter int ID_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [INT_SEL_WIDTH-1:0] int_vec,
  input  logic int_en_n,
  input  logic [INT_SEL_WIDTH-1:0] int_mask,
  input  logic pipe_idle,
  input  logic eoi,
  output logic stop,
  output logic setINTR,
  output logic int_jump,
  output logic [ADDR_WIDTH-1:0] int_addr,
  output logic [ID_W-1:0] int_id,
  output logic [INT_SEL_WIDTH-1:0] pending,
  output logic [INT_SEL_WIDTH-1:0] in_service
);
  typedef enum logic [1:0] {IDLE, STALL, JUMP, SERVICE} state_t;
  localparam logic [INT_SEL_WIDTH-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [INT_SEL_WIDTH-1:0] prev_q, pending_q, pending_d, in_service_q, in_service_d;
  logic [INT_SEL_WIDTH-1:0] rise, elig, id_oh;
  logic [ID_W-1:0] int_id_q, int_id_d, win;
  logic [ADDR_WIDTH-1:0] int_addr_q, int_addr_d;
  logic stop_q, stop_d, set_intr_q, set_intr_d, int_jump_q, int_jump_d, preempt;
  assign rise = int_vec & ~prev_q;
  assign elig = int_en_n ? '0 : pending_q & ~int_mask;
  assign id_oh = ONE << int_id_q;
`ifdef MBSCORE_INT_NEST_EN
  assign preempt = |(elig & ((in_service_q & (~in_service_q + ONE)) - ONE));
`else
  assign preempt = 1'b0;
`endif
  always_comb begin
    win = '0;
    for (int i = INT_SEL_WIDTH - 1; i >= 0; i--) win = elig[i] ? ID_W'(i) : win;
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q | rise;
    in_service_d = in_service_q;
    int_id_d = int_id_q;
    int_addr_d = '0;
    stop_d = 1'b0;
    set_intr_d = 1'b0;
    int_jump_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = |elig ? STALL : IDLE;
        int_id_d = |elig ? win : int_id_q;
        stop_d = |elig;
      end
      STALL: begin
        stop_d = 1'b1;
        state_d = pipe_idle ? JUMP : STALL;
        set_intr_d = pipe_idle;
        int_jump_d = pipe_idle;
        int_addr_d = pipe_idle ? VEC_BASE + ADDR_WIDTH'(int_id_q) * ADDR_WIDTH'(VEC_STRIDE) : '0;
      end
      JUMP: begin
        state_d = SERVICE;
        pending_d = (pending_q & ~id_oh) | rise;
        in_service_d = in_service_q | id_oh;
      end
      SERVICE: begin
        in_service_d = eoi ? in_service_q & (in_service_q - ONE) : in_service_q;
        state_d = eoi ? (in_service_d == '0 ? IDLE : SERVICE) : (preempt ? STALL : SERVICE);
        int_id_d = (!eoi && preempt) ? win : int_id_q;
        stop_d = !eoi && preempt;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q <= '0;
      pending_q <= '0;
      in_service_q <= '0;
      int_id_q <= '0;
      int_addr_q <= '0;
      stop_q <= 1'b0;
      set_intr_q <= 1'b0;
      int_jump_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= int_vec;
      pending_q <= pending_d;
      in_service_q <= in_service_d;
      int_id_q <= int_id_d;
      int_addr_q <= int_addr_d;
      stop_q <= stop_d;
      set_intr_q <= set_intr_d;
      int_jump_q <= int_jump_d;
    end
  end
  assign stop = stop_q;
  assign setINTR = set_intr_q;
  assign int_jump = int_jump_q;
  assign int_addr = int_addr_q;
  assign int_id = int_id_q;
  assign pending = pending_q;
  assign in_service = in_service_q;
endmodule

// File: tb/tb_mbscore_int_arbiter.sv
// tb_mbscore_int_arbiter: scoreboarded random and directed checks of interrupt grant order, vectors and sequencing
module tb_mbscore_int_arbiter;
  typedef struct {
    logic [2:0] id;
    logic [31:0] addr;
  } grant_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic int_en_n = 1'b0;
  logic pipe_idle = 1'b1;
  logic eoi = 1'b0;
  logic [6:0] int_vec = '0;
  logic [6:0] int_mask = '0;
  logic stop, setINTR, int_jump;
  logic [31:0] int_addr;
  logic [2:0] int_id;
  logic [6:0] pending, in_service;
  int checks = 0;
  int fails = 0;
  grant_t exp_q[$];
  grant_t mon_g;
  logic [6:0] pend_m;
  mbscore_int_arbiter dut (
    .clk(clk), .rst(rst), .int_vec(int_vec), .int_en_n(int_en_n), .int_mask(int_mask),
    .pipe_idle(pipe_idle), .eoi(eoi), .stop(stop), .setINTR(setINTR), .int_jump(int_jump),
    .int_addr(int_addr), .int_id(int_id), .pending(pending), .in_service(in_service)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic grant_t grant_of(input int id);
    grant_t g;
    g.id = 3'(id);
    g.addr = 32'h100 + 32'(id) * 32'd16;
    return g;
  endfunction
  task automatic push_bits(input logic [6:0] b);
    for (int i = 0; i < 7; i++) if (b[i]) exp_q.push_back(grant_of(i));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic eoi_pulse();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask
  task automatic wait_jump(input string nm, input bit rnd_idle);
    int n;
    n = 0;
    while (!int_jump && n < 40) begin
      pipe_idle = rnd_idle ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk(nm, 32'(int_jump), 32'd1);
    pipe_idle = 1'b1;
  endtask
  task automatic serve(input int id);
    wait_jump("rand_jump_timeout", 1'b1);
    pend_m[id] = 1'b0;
    tick();
    chk("rand_pending", 32'(pending), 32'(pend_m));
    chk("rand_in_service", 32'(in_service), 32'(7'b1 << id));
    chk("rand_stop_service", 32'(stop), 32'd0);
    eoi_pulse();
    chk("rand_in_service_eoi", 32'(in_service), 32'd0);
  endtask
  always @(negedge clk) begin
    if (int_jump) begin
      if (exp_q.size() == 0) chk("unexpected_jump", 32'd1, 32'd0);
      else begin
        mon_g = exp_q.pop_front();
        chk("jump_addr", int_addr, mon_g.addr);
        chk("jump_id", 32'(int_id), 32'(mon_g.id));
        chk("jump_setINTR", 32'(setINTR), 32'd1);
        chk("jump_stop", 32'(stop), 32'd1);
      end
    end else begin
      chk("idle_addr", int_addr, 32'd0);
      chk("idle_setINTR", 32'(setINTR), 32'd0);
    end
  end
  initial begin
    logic [6:0] s, m;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_stop", 32'(stop), 32'd0);
    chk("reset_jump", 32'(int_jump), 32'd0);
    chk("reset_id", 32'(int_id), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_in_service", 32'(in_service), 32'd0);
    int_vec = 7'b0000100;
    exp_q.push_back(grant_of(2));
    tick();
    int_vec = '0;
    chk("lat_pending", 32'(pending), 32'h4);
    chk("lat_stop0", 32'(stop), 32'd0);
    tick();
    chk("lat_stall_stop", 32'(stop), 32'd1);
    chk("lat_stall_nojump", 32'(int_jump), 32'd0);
    tick();
    chk("lat_jump", 32'(int_jump), 32'd1);
    chk("lat_addr", int_addr, 32'h120);
    chk("lat_id", 32'(int_id), 32'd2);
    tick();
    chk("lat_srv_stop", 32'(stop), 32'd0);
    chk("lat_srv_jump", 32'(int_jump), 32'd0);
    chk("lat_srv_pending", 32'(pending), 32'd0);
    chk("lat_srv_in_service", 32'(in_service), 32'h4);
    eoi_pulse();
    chk("lat_eoi", 32'(in_service), 32'd0);
    int_vec = 7'b0100010;
    push_bits(7'b0100010);
    tick();
    int_vec = '0;
    wait_jump("prio_jump1", 1'b0);
    tick();
    chk("prio_in_service1", 32'(in_service), 32'h2);
    chk("prio_pending1", 32'(pending), 32'h20);
    eoi_pulse();
    wait_jump("prio_jump5", 1'b0);
    tick();
    chk("prio_in_service5", 32'(in_service), 32'h20);
    eoi_pulse();
    int_mask = 7'b0001000;
    int_vec = 7'b0001000;
    tick();
    int_vec = '0;
    tick();
    tick();
    chk("mask_pending", 32'(pending), 32'h8);
    chk("mask_no_stop", 32'(stop), 32'd0);
    int_mask = '0;
    push_bits(7'b0001000);
    tick();
    chk("unmask_stop", 32'(stop), 32'd1);
    wait_jump("unmask_jump", 1'b0);
    tick();
    eoi_pulse();
    pipe_idle = 1'b0;
    int_vec = 7'b1000000;
    push_bits(7'b1000000);
    tick();
    int_vec = '0;
    tick();
    int_en_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_stop", 32'(stop), 32'd1);
      chk("stall_nojump", 32'(int_jump), 32'd0);
      tick();
    end
    pipe_idle = 1'b1;
    tick();
    chk("stall_jump", 32'(int_jump), 32'd1);
    chk("stall_addr", int_addr, 32'h160);
    int_en_n = 1'b0;
    tick();
    eoi_pulse();
    int_vec = 7'b0010000;
    push_bits(7'b0010000);
    tick();
    int_vec = '0;
    wait_jump("nest_jump4", 1'b0);
    tick();
    int_vec = 7'b0000001;
`ifdef MBSCORE_INT_NEST_EN
    push_bits(7'b0000001);
    tick();
    int_vec = '0;
    wait_jump("nest_preempt", 1'b0);
    chk("nest_addr", int_addr, 32'h100);
    tick();
    chk("nest_in_service", 32'(in_service), 32'h11);
    eoi_pulse();
    chk("nest_eoi1", 32'(in_service), 32'h10);
    chk("nest_eoi1_stop", 32'(stop), 32'd0);
    eoi_pulse();
    chk("nest_eoi2", 32'(in_service), 32'd0);
`else
    tick();
    int_vec = '0;
    for (int i = 0; i < 5; i++) begin
      chk("nonest_stop", 32'(stop), 32'd0);
      tick();
    end
    chk("nonest_in_service", 32'(in_service), 32'h10);
    push_bits(7'b0000001);
    eoi_pulse();
    wait_jump("nonest_jump0", 1'b0);
    tick();
    chk("nonest_in_service0", 32'(in_service), 32'h1);
    eoi_pulse();
`endif
    int_vec = 7'b0000100;
    push_bits(7'b0000100);
    tick();
    int_vec = '0;
    wait_jump("rst_jump", 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstj_stop", 32'(stop), 32'd0);
    chk("rstj_setINTR", 32'(setINTR), 32'd0);
    chk("rstj_jump", 32'(int_jump), 32'd0);
    chk("rstj_addr", int_addr, 32'd0);
    chk("rstj_id", 32'(int_id), 32'd0);
    chk("rstj_pending", 32'(pending), 32'd0);
    chk("rstj_in_service", 32'(in_service), 32'd0);
    tick();
    chk("rstj_idle_stop", 32'(stop), 32'd0);
    pend_m = '0;
    for (int t = 0; t < 25; t++) begin
      s = 7'($urandom_range(1, 127));
      m = 7'($urandom_range(0, 127));
      int_mask = m;
      int_vec = s;
      pend_m = pend_m | s;
      push_bits(s & ~m);
      tick();
      int_vec = '0;
      if ((s & ~m) == '0) begin
        tick();
        tick();
        chk("rand_masked_no_stop", 32'(stop), 32'd0);
        chk("rand_masked_pending", 32'(pending), 32'(pend_m));
      end
      for (int i = 0; i < 7; i++) if (s[i] && !m[i]) serve(i);
      if ((s & m) != '0) begin
        int_mask = '0;
        push_bits(s & m);
        for (int i = 0; i < 7; i++) if (s[i] && m[i]) serve(i);
      end
      chk("rand_drained", 32'(pending), 32'd0);
    end
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
